// File: rtl/riscv_pkg.sv
// Shared core definitions: bus/word-address widths, reset PC and the fetch FSM encoding.
package riscv_pkg;

  localparam int unsigned BUS_WIDTH = 32;
  localparam int unsigned PC_AW     = BUS_WIDTH - 2;
  localparam int unsigned INSTR_DW  = 32;

  localparam logic [PC_AW-1:0] RESET_WORD_PC = '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    HOLD     = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl_incr.sv
// Word incrementer: next sequential word address, wrapping modulo 2^AW.
module pc_fetch_ctrl_incr #(
  parameter int unsigned AW = 30
) (
  input  logic [AW-1:0] pc_i,
  output logic [AW-1:0] pc_inc_c
);

  assign pc_inc_c = pc_i + AW'(1);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-path PC owner: one outstanding imem fetch, valid/ready delivery to decode.
// Optional FETCH_PERF_EN adds saturating fetched/stall performance counters.
module pc_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned    AW       = PC_AW,
  parameter int unsigned    DW       = INSTR_DW,
  parameter logic [AW-1:0]  RESET_PC = RESET_WORD_PC
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef FETCH_PERF_EN
  output logic [31:0]   perf_fetched_o,
  output logic [31:0]   perf_stall_o,
`endif
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [DW-1:0] imem_rdata_i,
  output logic          instr_valid_o,
  output logic [DW-1:0] instr_o,
  output logic [AW-1:0] instr_pc_o,
  input  logic          instr_ready_i
);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic [DW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          drop_q, drop_d;
  logic          req_q, req_d;
  logic [AW-1:0] pc_inc;

  pc_fetch_ctrl_incr #(.AW(AW)) u_incr (
    .pc_i     (instr_pc_q),
    .pc_inc_c (pc_inc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      instr_pc_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      instr_pc_q <= instr_pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
      req_q      <= req_d;
    end
  end

  // Next state; redirect takes priority over every handshake in every state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    instr_pc_d = instr_pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    drop_d     = drop_q;

    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      valid_d = 1'b0;
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_gnt_i) begin
            fetch_pc_d = pc_q;
            drop_d     = 1'b1;
            state_d    = WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (imem_rvalid_i) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end
        HOLD: state_d = REQ;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_gnt_i) begin
            fetch_pc_d = pc_q;
            state_d    = WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (imem_rvalid_i) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = REQ;
            end else begin
              instr_d    = imem_rdata_i;
              instr_pc_d = fetch_pc_q;
              valid_d    = 1'b1;
              state_d    = HOLD;
            end
          end
        end
        HOLD: begin
          if (instr_ready_i) begin
            valid_d = 1'b0;
            pc_d    = pc_inc;
            state_d = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    req_d = (state_d == REQ);
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  // A redirect in HOLD drops the instruction, so it is not a handshake.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (valid_q && instr_ready_i && !redirect_i && (perf_fetched_q != '1)) begin
      perf_fetched_d = perf_fetched_q + 32'(1);
    end
    if (!valid_q && (state_q != IDLE) && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'(1);
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule
